mp_ram: RTL and testbench

- Parametrised multi-read-port RAM; next generation of the team's dual-port RAM primitive.
- Provides 1 synchronous write port with byte-lane enables and NUM_RD_PORTS synchronous (registered) read ports.
- Runs a hardware clear sequence after reset, so contents are defined before first use.
- Used as register-file / buffer storage in datapath blocks that need multiple same-cycle reads.

---
 rtl/mp_ram_pkg.sv | 17 +
 rtl/mp_ram_rd_port.sv | 75 +++++++
 rtl/mp_ram.sv | 112 +++++++++++
 tb/tb_mp_ram.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_ram_pkg.sv
// Shared types and helpers for the multi-read-port RAM.
package mp_ram_pkg;

    typedef enum logic [0:0] {
        MP_RAM_CLEAR,
        MP_RAM_READY
    } mp_ram_state_e;

    // Address bits needed to reach the highest valid word, never less than one.
    function automatic int unsigned mp_ram_addr_width(input int unsigned base_addr,
                                                      input int unsigned ram_depth);
        int unsigned w;
        w = $clog2(base_addr + ram_depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mp_ram_rd_port.sv
// One registered read port: range check, optional same-edge write merge, data/valid registers.
// Write-first merging is enabled by defining MP_RAM_WR_BYPASS_EN.
module mp_ram_rd_port
    import mp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned ADDR_WIDTH = 4,
    localparam int unsigned NUM_LANES = DATA_WIDTH / BYTE_WIDTH,
    localparam int unsigned IDX_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_req,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic [RAM_DEPTH*DATA_WIDTH-1:0] mem_flat,
    input  logic                            wr_fire,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [NUM_LANES-1:0]            wr_byte_en,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            rd_valid
);

    logic [31:0]           rd_off;
    logic                  in_range;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_comb begin
        // Unsigned wrap turns below-base addresses into huge offsets.
        rd_off   = 32'(rd_addr) - BASE_ADDR;
        in_range = rd_off < RAM_DEPTH;
        rd_idx   = IDX_WIDTH'(rd_off);
        data_d   = '0;
        if (in_range) begin
            data_d = mem_flat[rd_idx*DATA_WIDTH +: DATA_WIDTH];
        end
`ifdef MP_RAM_WR_BYPASS_EN
        if (wr_fire && (wr_addr == rd_addr)) begin
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                if (wr_byte_en[k]) begin
                    data_d[k*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
`endif
    end

`ifdef MP_RAM_WR_BYPASS_EN
`else
    logic unused_wr;
    assign unused_wr = ^{wr_fire, wr_addr, wr_byte_en, wr_data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_req;
            if (rd_req) begin
                data_q <= data_d;
            end
        end
    end

    assign data_out = data_q;
    assign rd_valid = valid_q;

endmodule

// File: rtl/mp_ram.sv
// Multi-read-port RAM with byte-lane writes and a post-reset hardware clear sequence.
// Define MP_RAM_WR_BYPASS_EN for write-first same-edge collisions (default read-first).
module mp_ram
    import mp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned RAM_DEPTH    = 16,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned NUM_RD_PORTS = 2,
    localparam int unsigned ADDR_WIDTH  = mp_ram_addr_width(BASE_ADDR, RAM_DEPTH),
    localparam int unsigned NUM_LANES   = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_wr_en,
    input  logic [ADDR_WIDTH-1:0]              i_wr_addr,
    input  logic [NUM_LANES-1:0]               i_wr_byte_en,
    input  logic [DATA_WIDTH-1:0]              i_data_in,
    input  logic [NUM_RD_PORTS-1:0]            i_rd_en,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] o_data_out,
    output logic [NUM_RD_PORTS-1:0]            o_rd_valid,
    output logic                               o_busy
);

    localparam int unsigned IDX_WIDTH = $clog2(RAM_DEPTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RAM_DEPTH - 1);

    mp_ram_state_e                   state_q, state_d;
    logic [IDX_WIDTH-1:0]            clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]           mem_q [RAM_DEPTH];
    logic [RAM_DEPTH*DATA_WIDTH-1:0] mem_flat;
    logic                            ready;
    logic                            wr_fire;
    logic [31:0]                     wr_off;
    logic [IDX_WIDTH-1:0]            wr_idx;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == MP_RAM_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_IDX) begin
                state_d   = MP_RAM_READY;
                clr_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MP_RAM_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign ready  = (state_q == MP_RAM_READY);
    assign o_busy = ~ready;

    always_comb begin
        wr_off  = 32'(i_wr_addr) - BASE_ADDR;
        wr_idx  = IDX_WIDTH'(wr_off);
        wr_fire = ready && i_wr_en && (wr_off < RAM_DEPTH);
    end

    // Storage is never reset; the CLEAR walk zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == MP_RAM_CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wr_fire) begin
                for (int unsigned k = 0; k < NUM_LANES; k++) begin
                    if (i_wr_byte_en[k]) begin
                        mem_q[wr_idx][k*BYTE_WIDTH +: BYTE_WIDTH] <=
                            i_data_in[k*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    for (genvar e = 0; e < RAM_DEPTH; e++) begin : g_flat
        assign mem_flat[e*DATA_WIDTH +: DATA_WIDTH] = mem_q[e];
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
        mp_ram_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .BYTE_WIDTH (BYTE_WIDTH),
            .RAM_DEPTH  (RAM_DEPTH),
            .BASE_ADDR  (BASE_ADDR),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_rd_port (
            .clk        (clk),
            .rst        (rst),
            .rd_req     (ready & i_rd_en[p]),
            .rd_addr    (i_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .mem_flat   (mem_flat),
            .wr_fire    (wr_fire),
            .wr_addr    (i_wr_addr),
            .wr_byte_en (i_wr_byte_en),
            .wr_data    (i_data_in),
            .data_out   (o_data_out[p*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid   (o_rd_valid[p])
        );
    end

endmodule

// File: tb/tb_mp_ram.sv
// Bench for mp_ram: two instances (base 0 / depth 16 and base 4 / depth 8) share stimulus
// and are checked every cycle against a word-array model, plus directed literal checks.
module tb_mp_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic [63:0] data0, data1;
    logic [1:0]  valid0, valid1;
    logic        busy0, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mp_ram #(
        .DATA_WIDTH   (32),
        .BYTE_WIDTH   (8),
        .RAM_DEPTH    (16),
        .BASE_ADDR    (0),
        .NUM_RD_PORTS (2)
    ) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_byte_en (wr_be),
        .i_data_in    (wr_data),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .o_data_out   (data0),
        .o_rd_valid   (valid0),
        .o_busy       (busy0)
    );

    mp_ram #(
        .DATA_WIDTH   (32),
        .BYTE_WIDTH   (8),
        .RAM_DEPTH    (8),
        .BASE_ADDR    (4),
        .NUM_RD_PORTS (2)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_byte_en (wr_be),
        .i_data_in    (wr_data),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .o_data_out   (data1),
        .o_rd_valid   (valid1),
        .o_busy       (busy1)
    );

    // ---------------- reference model ----------------
    logic [31:0] mdl_mem   [2][16];
    logic [31:0] exp_data  [2][2];
    logic        exp_valid [2][2];
    int          clr_left  [2];
    bit          started = 1'b0;

    function automatic int base_of(input int i);
        return (i == 0) ? 0 : 4;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? 16 : 8;
    endfunction

    function automatic bit in_rng(input int i, input int a);
        return (a >= base_of(i)) && (a < base_of(i) + depth_of(i));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[k*8 +: 8] = nw[k*8 +: 8];
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    // Contents are unobservable until the clear walk ends, so zero them now.
                    clr_left[i] = depth_of(i);
                    for (int e = 0; e < 16; e++) mdl_mem[i][e] = '0;
                    for (int p = 0; p < 2; p++) begin
                        exp_valid[i][p] = 1'b0;
                        exp_data[i][p]  = '0;
                    end
                    started = 1'b1;
                end else if (clr_left[i] > 0) begin
                    clr_left[i]--;
                    for (int p = 0; p < 2; p++) exp_valid[i][p] = 1'b0;
                end else begin
                    bit wr_hit;
                    wr_hit = wr_en && in_rng(i, int'(wr_addr));
                    for (int p = 0; p < 2; p++) begin
                        int a;
                        logic [31:0] w;
                        a = int'(rd_addr[p*4 +: 4]);
                        exp_valid[i][p] = rd_en[p];
                        if (rd_en[p]) begin
                            w = '0;
                            if (in_rng(i, a)) begin
                                w = mdl_mem[i][a - base_of(i)];
`ifdef MP_RAM_WR_BYPASS_EN
                                if (wr_hit && (a == int'(wr_addr))) w = merge(w, wr_data, wr_be);
`endif
                            end
                            exp_data[i][p] = w;
                        end
                    end
                    if (wr_hit) begin
                        mdl_mem[i][int'(wr_addr) - base_of(i)] =
                            merge(mdl_mem[i][int'(wr_addr) - base_of(i)], wr_data, wr_be);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                check("dut0 busy", 64'(busy0), 64'(clr_left[0] > 0));
                check("dut1 busy", 64'(busy1), 64'(clr_left[1] > 0));
                for (int p = 0; p < 2; p++) begin
                    check($sformatf("dut0 valid%0d", p), 64'(valid0[p]), 64'(exp_valid[0][p]));
                    check($sformatf("dut1 valid%0d", p), 64'(valid1[p]), 64'(exp_valid[1][p]));
                    check($sformatf("dut0 data%0d", p), 64'(data0[p*32 +: 32]),
                          64'(exp_data[0][p]));
                    check($sformatf("dut1 data%0d", p), 64'(data1[p*32 +: 32]),
                          64'(exp_data[1][p]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_be   = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int n1;
        rst = 1'b1;
        idle();

        // Clear timing: two reset cycles, then count edges until busy drops.
        tick();
        tick();
        rst = 1'b0;
        n0 = 0;
        n1 = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (!busy1 && n1 == 0) n1 = n;
            if (!busy0) begin
                n0 = n;
                break;
            end
        end
        check("clear edges dut0", 64'(n0), 64'd16);
        check("clear edges dut1", 64'(n1), 64'd8);

        // Every word reads back zero after the clear walk.
        for (int a = 0; a < 16; a++) begin
            rd_en   = 2'b11;
            rd_addr = {4'(15 - a), 4'(a)};
            tick();
            check("cleared word", data0, 64'h0);
            check("cleared valid", 64'(valid0), 64'h3);
        end
        idle();

        // Byte lanes.
        write(4'd3, 32'hDEAD_BEEF, 4'hF);
        tick();
        write(4'd3, 32'h1122_3344, 4'h5);
        tick();
        idle();
        rd_en   = 2'b01;
        rd_addr = 8'h03;
        tick();
        check("byte lanes", 64'(data0[31:0]), 64'hDE22_BE44);
        check("byte lanes valid", 64'(valid0), 64'h1);
        idle();

        // Dual read, and the same read on the offset instance (addr 3 is below its base).
        write(4'd3, 32'hA, 4'hF);
        tick();
        write(4'd7, 32'hB, 4'hF);
        tick();
        idle();
        rd_en   = 2'b11;
        rd_addr = {4'd7, 4'd3};
        tick();
        check("dual read", data0, 64'h0000_000B_0000_000A);
        check("dual valid", 64'(valid0), 64'h3);
        check("below base", data1, 64'h0000_000B_0000_0000);
        check("below base valid", 64'(valid1), 64'h3);
        idle();

        // Same-edge collision.
        write(4'd5, 32'h1, 4'hF);
        tick();
        write(4'd5, 32'h2, 4'hF);
        rd_en   = 2'b01;
        rd_addr = 8'h05;
        tick();
`ifdef MP_RAM_WR_BYPASS_EN
        check("collision", 64'(data0[31:0]), 64'h2);
`else
        check("collision", 64'(data0[31:0]), 64'h1);
`endif
        wr_en = 1'b0;
        tick();
        check("after collision", 64'(data0[31:0]), 64'h2);
        idle();

        // Address 12 is past the end of the offset instance.
        write(4'd12, 32'hFF, 4'hF);
        tick();
        idle();
        for (int a = 4; a < 12; a++) begin
            rd_en   = 2'b11;
            rd_addr = {4'd12, 4'(a)};
            tick();
            if (a == 7) begin
                check("range keep", 64'(data1[31:0]), 64'hB);
                check("range past end", 64'(data1[63:32]), 64'h0);
                check("in range 12", 64'(data0[63:32]), 64'hFF);
            end
        end
        idle();

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_be   = 4'($urandom);
            wr_data = $urandom;
            rd_en   = 2'($urandom);
            rd_addr = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rd_addr[3:0] = wr_addr;
            if ($urandom_range(0, 3) == 0) rd_addr[7:4] = wr_addr;
            tick();
        end
        rst = 1'b0;
        idle();

        // Reset in the middle of a clear walk; writes during clear are dropped.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            if (n == 2) write(4'd1, 32'h55, 4'hF);
            else wr_en = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        check("busy at cnt 9", 64'(busy0), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n0 = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 1) write(4'd2, 32'h66, 4'hF);
            else wr_en = 1'b0;
            tick();
            if (!busy0) begin
                n0 = n;
                break;
            end
        end
        check("restart clear edges", 64'(n0), 64'd16);
        idle();
        rd_en   = 2'b11;
        rd_addr = {4'd2, 4'd1};
        tick();
        check("dropped writes", data0, 64'h0);
        check("dropped valid", 64'(valid0), 64'h3);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
